alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised multi-cycle ALU that succeeds the single-cycle combinational ALU in the MIPS datapath.
- Single-cycle ops (add/sub/logic/shift/compare) return a registered result one cycle after acceptance.
- Unsigned multiply and divide are iterative shift-add / restoring units; results go to out plus hi (MIPS HI/LO style).
- Sits in EX stage; the pipeline controller stalls on in_ready low.

Parameters:
WIDTH, 32, operand/result width (>=8, power of 2)
SHW, $clog2(WIDTH), shift-amount bits taken from in2

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operands/op presented
in_ready  output  1  unit can accept (high only in IDLE)
op  input  4  operation code (alu_mc_pkg)
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B / shift amount
out_valid  output  1  one-cycle pulse, result valid
out  output  WIDTH  result / product low / quotient
hi  output  WIDTH  product high / remainder; 0 for other ops
zero  output  1  out==0; for OP_BEQ, in1==in2
dz  output  1  divide-by-zero flag, valid with out_valid

Behaviour:
- Single clock domain. Reset is synchronous and active-high: clk and rst, rst sampled on rising edge of clk.
- Reset (sync, also mid-operation): state=IDLE, in_ready=1, out_valid=0, out=0, hi=0, zero=0, dz=0. Any in-flight mul/div is discarded with no out_valid.
- Accept when in_valid & in_ready at edge k.
- Ops: ADD=in1+in2 (wraps mod 2^WIDTH); SUB=in1-in2; AND; OR; NOR=~(in1|in2); SLL=in1<<in2[SHW-1:0]; SRL=in1>>in2[SHW-1:0] (logical); SLT=signed in1<in2 ? 1:0; SLTU=unsigned compare; BEQ: out=0, zero=(in1==in2); MULU; DIVU. Undefined codes: out=0, zero=1, out_valid still pulses.
- Single-cycle ops: out/hi/zero/dz registered at edge k, out_valid=1 for exactly the cycle after k. State stays IDLE, in_ready stays 1, so back-to-back issue gives throughput 1/cycle.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL on accepted MULU.
  - IDLE -> DIV on accepted DIVU (ALU_DIV_EN only).
  - MUL/DIV -> IDLE after WIDTH iteration edges.
- MUL: operands latched at k; one shift-add per cycle; counter runs WIDTH down to 1. out_valid pulses in the cycle after edge k+WIDTH with {hi,out}=in1*in2 (full 2*WIDTH product). Latency WIDTH+1 cycles.
- DIV: restoring, one quotient bit per cycle, same latency; out=quotient, hi=remainder.
- Divide by zero: detected at accept, same latency; out={WIDTH{1}}, hi=in1, dz=1.
- in_ready=0 throughout MUL/DIV; in_valid is ignored there. in_ready returns to 1 in the same cycle as out_valid, so a new op may be accepted on that edge.
- zero is computed on the final registered out (except BEQ). Outputs hold their last value while out_valid=0.

Optional Feature:
ALU_DIV_EN
- Defined: DIV state and divider datapath are built; DIVU behaves as above.
- Undefined: no divider logic. DIVU completes as a single-cycle op with out=0, hi=0, dz=1.

Decomposition:
- Package alu_mc_pkg: op_t 4-bit enum (OP_ADD=0, SUB, AND, OR, NOR, SLL, SRL, SLT, SLTU, BEQ, MULU, DIVU), state_t enum, WIDTH-independent constants.
- One sub-module alu_mc_iter: shared shift/accumulate datapath for mul and div (mode input, start, WIDTH-cycle counter, done). Top holds the FSM, the single-cycle ops and the output registers.

Test Plan:
- ADD 29+21, then SUB 5-5 back-to-back on consecutive cycles -> out_valid on two consecutive cycles; out=50 (zero=0), then out=0 (zero=1). in_ready never drops.
- SLT in1=0xFFFFFFFF, in2=3 -> out=1; SLTU same operands -> out=0. SLL in1=4, in2=7 -> out=512. NOR 5,9 -> out=0xFFFFFFF2. BEQ 1,1 -> out=0, zero=1.
- MULU 0xFFFFFFFF*2 -> in_ready low 32 cycles; out_valid in the 33rd cycle after accept; out=0xFFFFFFFE, hi=1. in_valid held high during busy is not accepted.
- DIVU 100/7 (ALU_DIV_EN) -> out=14, hi=2, dz=0 after 33 cycles. DIVU 9/0 -> out=0xFFFFFFFF, hi=9, dz=1. Without macro: DIVU 100/7 -> 1-cycle, out=0, dz=1.
- Assert rst for one cycle 10 cycles into a MULU -> next cycle in_ready=1, out=0, no out_valid pulse; new ADD 1+1 -> out=2.
- WIDTH=8 build: MULU 0xFF*0xFF -> out=0x01, hi=0xFE after 9 cycles; SLL uses in2[2:0] only (in2=9 shifts by 1).

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and iterator modes.
// Optional macro ALU_DIV_EN selects whether the divider is built.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTU = 4'd8,
    OP_BEQ  = 4'd9,
    OP_MULU = 4'd10,
    OP_DIVU = 4'd11
  } op_t;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv
  } state_t;

  localparam logic ITER_MUL = 1'b0;
  localparam logic ITER_DIV = 1'b1;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath shared by shift-add multiply and restoring divide; one step per cycle.
// The divide path and mode input exist only when ALU_DIV_EN is defined.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  logic             mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic [WIDTH-1:0] acc_hi_d, acc_lo_d, addend;
  logic [WIDTH:0]   sum;
`ifdef ALU_DIV_EN
  logic             mode_q;
  logic [WIDTH:0]   diff;
`endif

  // acc_hi is the partial product / remainder, acc_lo the multiplier / quotient.
  always_comb begin
    addend   = acc_lo_q[0] ? opnd_q : {WIDTH{1'b0}};
    sum      = {1'b0, acc_hi_q} + {1'b0, addend};
    acc_hi_d = sum[WIDTH:1];
    acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    diff = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opnd_q};
    if (mode_q == ITER_DIV) begin
      // diff MSB set means the trial subtraction borrowed: restore.
      acc_hi_d = diff[WIDTH] ? {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]} : diff[WIDTH-1:0];
      acc_lo_d = {acc_lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
`ifdef ALU_DIV_EN
      mode_q   <= ITER_MUL;
`endif
    end else if (start) begin
      cnt_q    <= CW'(WIDTH);
      acc_hi_q <= '0;
      acc_lo_q <= a;
      opnd_q   <= b;
`ifdef ALU_DIV_EN
      mode_q   <= mode;
`endif
    end else if (cnt_q != '0) begin
      cnt_q    <= cnt_q - 1'b1;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end

  assign last = (cnt_q == CW'(1));
  assign lo   = acc_lo_d;
  assign hi   = acc_hi_d;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative MULU/DIVU with HI/LO results.
// Define ALU_DIV_EN to build the divider; otherwise DIVU returns dz=1 in one cycle.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             dz
);

  state_t           state_q, state_d;
  op_t              opc;
  logic [WIDTH-1:0] res, out_q, out_d, hi_q, hi_d;
  logic [WIDTH-1:0] iter_lo, iter_hi;
  logic             zero_q, zero_d, dz_q, dz_d, valid_q, valid_d;
  logic             accept, start, iter_last;
`ifdef ALU_DIV_EN
  logic             dz_pend_q, dz_pend_d, iter_mode;
`endif

  assign opc      = op_t'(op);
  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid & in_ready;

  always_comb begin
    res = '0;
    case (opc)
      OP_ADD:  res = in1 + in2;
      OP_SUB:  res = in1 - in2;
      OP_AND:  res = in1 & in2;
      OP_OR:   res = in1 | in2;
      OP_NOR:  res = ~(in1 | in2);
      OP_SLL:  res = in1 << in2[SHW-1:0];
      OP_SRL:  res = in1 >> in2[SHW-1:0];
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, in1 < in2};
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    dz_d    = dz_q;
    valid_d = 1'b0;
    start   = 1'b0;
`ifdef ALU_DIV_EN
    dz_pend_d = dz_pend_q;
    iter_mode = ITER_MUL;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (opc == OP_MULU) begin
            start   = 1'b1;
            state_d = StMul;
`ifdef ALU_DIV_EN
          end else if (opc == OP_DIVU) begin
            start     = 1'b1;
            iter_mode = ITER_DIV;
            state_d   = StDiv;
            dz_pend_d = (in2 == '0);
`endif
          end else begin
            valid_d = 1'b1;
            out_d   = res;
            hi_d    = '0;
            zero_d  = (opc == OP_BEQ) ? (in1 == in2) : (res == '0);
            // Only reachable for DIVU when the divider is not built.
            dz_d    = (opc == OP_DIVU);
          end
        end
      end
      StMul, StDiv: begin
        if (iter_last) begin
          valid_d = 1'b1;
          state_d = StIdle;
          out_d   = iter_lo;
          hi_d    = iter_hi;
          dz_d    = 1'b0;
`ifdef ALU_DIV_EN
          if (state_q == StDiv && dz_pend_q) begin
            out_d = '1;
            dz_d  = 1'b1;
          end
`endif
          zero_d = (out_d == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      out_q     <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b0;
      dz_q      <= 1'b0;
      valid_q   <= 1'b0;
`ifdef ALU_DIV_EN
      dz_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      hi_q      <= hi_d;
      zero_q    <= zero_d;
      dz_q      <= dz_d;
      valid_q   <= valid_d;
`ifdef ALU_DIV_EN
      dz_pend_q <= dz_pend_d;
`endif
    end
  end

  alu_mc_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .start(start),
`ifdef ALU_DIV_EN
    .mode (iter_mode),
`endif
    .a    (in1),
    .b    (in2),
    .last (iter_last),
    .lo   (iter_lo),
    .hi   (iter_hi)
  );

  assign out_valid = valid_q;
  assign out       = out_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus random ops against an arithmetic model.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] in1, in2;
  logic             out_valid;
  logic [WIDTH-1:0] out, hi;
  logic             zero, dz;

  int checks = 0;
  int errors = 0;

  alu_mc #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .in1      (in1),
    .in2      (in2),
    .out_valid(out_valid),
    .out      (out),
    .hi       (hi),
    .zero     (zero),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got no summary, required summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the arithmetic definitions; lat = cycles from accept to pulse.
  task automatic model(input logic [3:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic [WIDTH-1:0] r, output logic [WIDTH-1:0] h,
                       output logic z, output logic d, output int lat);
    logic [2*WIDTH-1:0] p;
    r = '0; h = '0; d = 1'b0; lat = 1;
    case (o)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = ~(a | b);
      4'd5:  r = a << (b % WIDTH);
      4'd6:  r = a >> (b % WIDTH);
      4'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd8:  r = (a < b) ? 1 : 0;
      4'd9:  r = '0;
      4'd10: begin
        p   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        r   = p[WIDTH-1:0];
        h   = p[2*WIDTH-1:WIDTH];
        lat = WIDTH + 1;
      end
      4'd11: begin
`ifdef ALU_DIV_EN
        lat = WIDTH + 1;
        if (b == 0) begin
          r = '1; h = a; d = 1'b1;
        end else begin
          r = a / b; h = a % b;
        end
`else
        d = 1'b1;
`endif
      end
      default: r = '0;
    endcase
    z = (o == 4'd9) ? (a == b) : (r == 0);
  endtask

  // Issue one op, hold in_valid high with junk while busy, then check result and timing.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] er, eh;
    logic ez, ed;
    int el, n, busy;
    model(o, a, b, er, eh, ez, ed, el);
    @(negedge clk);
    chk({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    @(negedge clk);
    op = 4'd0; in1 = 1; in2 = 1;
    n = 1; busy = 0;
    while (!out_valid && n < el + 8) begin
      if (!in_ready) busy++;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_latency"}, n, el);
    chk({tag, "_busy"}, busy, el - 1);
    chk({tag, "_ready_at_pulse"}, in_ready, 1);
    chk({tag, "_out"}, out, er);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_dz"}, dz, ed);
    @(negedge clk);
    chk({tag, "_pulse_len"}, out_valid, 0);
  endtask

  initial begin
    int spurious;
    logic [WIDTH-1:0] ra, rb;
    logic [3:0] ro;
    rst = 1'b1; in_valid = 1'b0; op = '0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_hi", hi, 0);
    chk("rst_zero", zero, 0);
    chk("rst_dz", dz, 0);
    rst = 1'b0;

    // Back-to-back single-cycle ops.
    @(negedge clk);
    in_valid = 1'b1; op = OP_ADD; in1 = 29; in2 = 21;
    @(negedge clk);
    chk("b2b_add_valid", out_valid, 1);
    chk("b2b_add_out", out, 50);
    chk("b2b_add_zero", zero, 0);
    chk("b2b_ready1", in_ready, 1);
    op = OP_SUB; in1 = 5; in2 = 5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_sub_valid", out_valid, 1);
    chk("b2b_sub_out", out, 0);
    chk("b2b_sub_zero", zero, 1);
    chk("b2b_ready2", in_ready, 1);
    @(negedge clk);
    chk("b2b_idle_valid", out_valid, 0);

    run_op("slt", OP_SLT, '1, 3);
    run_op("sltu", OP_SLTU, '1, 3);
    run_op("sll", OP_SLL, 4, 7);
    run_op("sll_wrap", OP_SLL, 4, WIDTH + 1);
    run_op("srl", OP_SRL, '1, WIDTH - 1);
    run_op("nor", OP_NOR, 5, 9);
    run_op("beq_eq", OP_BEQ, 1, 1);
    run_op("beq_ne", OP_BEQ, 1, 2);
    run_op("mul_max2", OP_MULU, '1, 2);
    run_op("mul_maxmax", OP_MULU, '1, '1);
    run_op("div_100_7", OP_DIVU, 100, 7);
    run_op("div_by0", OP_DIVU, 9, 0);
    run_op("undef", 4'hF, 3, 4);

    // Reset in the middle of a multiply.
    @(negedge clk);
    in_valid = 1'b1; op = OP_MULU; in1 = 1234; in2 = 5678;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_out", out, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_valid", out_valid, 0);
    spurious = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    chk("midrst_no_pulse", spurious, 0);
    run_op("post_rst_add", OP_ADD, 1, 1);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 12));
      ra = WIDTH'({$urandom(), $urandom()});
      rb = WIDTH'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) rb = WIDTH'($urandom_range(0, 9));
      run_op("rand", ro, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
